output_unit: RTL and testbench
==============================

# output_unit

Serial bit presenter: the transmit-side counterpart of the button-driven 8-bit entry unit. It accepts an 8-bit value over a load handshake and presents it to the user one bit at a time, MSB first, on an LED-style output. The user steps through the bits with a "next" button, or the block steps through them automatically on a programmable period. It sits between the datapath result registers and the board LEDs/7-seg bit-index display.

## Interface
Parameters:
- STEP_CYCLES, default 50_000_000: auto-advance period in clk cycles; must be ≥ 2.
- CNT_W, default 26: width of the auto-step counter; must satisfy 2^CNT_W > STEP_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  block active; low forces IDLE and clears state
- load  in  1  request to start presenting load_value; sampled only when busy=0
- load_value  in  8  value to present
- btn_next  in  1  advance button (level, already debounced)
- auto_mode  in  1  1 = advance every STEP_CYCLES; btn_next still works
- busy  out  1  presentation in progress; load ignored
- bit_out  out  1  currently presented bit
- bit_valid  out  1  bit_out/bit_idx meaningful
- bit_idx  out  3  position of bit_out within the value (7 = MSB … 0 = LSB)
- done  out  1  one-cycle pulse after the LSB has been acknowledged

## Operation
- States: IDLE, SHOW.
- Rising-edge detect on btn_next: next_rise = btn_next & ~btn_next_d. btn_next_d resets to 0.
- IDLE:
  - busy=0, bit_valid=0, bit_out=0, bit_idx=0.
  - When enable & load: capture load_value into shift register sh, set cnt=0, clear the step counter, go to SHOW.
- SHOW:
  - busy=1, bit_valid=1, bit_out=sh[7], bit_idx=7−cnt.
  - Advance event adv = next_rise | tick. tick = auto_mode & (step counter == STEP_CYCLES−1).
  - If next_rise and tick fall in the same cycle, exactly one advance occurs.
  - On adv with cnt<7: sh <= {sh[6:0],1'b0}, cnt <= cnt+1, step counter cleared.
  - On adv with cnt==7: done pulses, go to IDLE.
- Step counter:
  - Increments each SHOW cycle while auto_mode=1.
  - Held at 0 while auto_mode=0 or in IDLE.
  - Cleared on every advance.
- load while busy=1 is ignored; no queueing.
- enable=0 in any state: next edge forces IDLE and clears sh, cnt and the step counter. done is not pulsed.
- Reset mid-presentation: all outputs return to reset values immediately (asynchronous). The edge detector also clears, so a button held through reset release registers one rise.

## Timing
- All outputs are registered. Reset values: busy=0, bit_valid=0, bit_out=0, bit_idx=0, done=0.
- Load accepted at edge N → from N+1: busy=1, bit_out=load_value[7], bit_idx=7.
- btn_next first sampled high at edge K (btn_next_d=0) → new bit visible from K+1. Holding the button produces no further advances.
- Auto mode: each bit is shown for exactly STEP_CYCLES cycles.
- Final advance at edge K → from K+1, for one cycle: done=1, busy=0, bit_valid=0. A load in that cycle is accepted at edge K+1.
- Full 8-bit presentation in auto mode: 8·STEP_CYCLES cycles from load acceptance to done.

## Structure
- Package output_unit_pkg: state enum {IDLE, SHOW}; localparam BITS=8.
- Sub-module rise_detect (1-bit registered edge detector, async reset). It is reusable by the entry unit.
- Everything else lives in one always block plus output assigns.

## Test plan
- Basic manual run:
  - Stimulus: load 8'hA5 in IDLE, then 8 btn_next pulses, each 3 cycles high.
  - Required: bit_out sequence 1,0,1,0,0,1,0,1; bit_idx 7..0; done exactly once, one cycle after the 8th rise; busy=0 afterwards.
- Auto mode:
  - Stimulus: STEP_CYCLES=4, auto_mode=1, load 8'h81.
  - Required: each bit held exactly 4 cycles; done 32 cycles after load acceptance.
- Simultaneous events:
  - Stimulus: next_rise coincident with tick.
  - Required: single advance (bit_idx drops by 1, not 2); step counter restarts from 0.
- Load while busy:
  - Stimulus: load 8'h0F during SHOW at bit_idx=5.
  - Required: ignored; the original value continues. A load in the done cycle is accepted.
- Abort:
  - Stimulus: enable=0 at bit_idx=3; separately, rst pulsed at bit_idx=4.
  - Required: IDLE with all outputs 0; no done; a subsequent load 8'h3C presents from its MSB.
- Held button:
  - Stimulus: btn_next held high for 20 cycles in SHOW, auto_mode=0.
  - Required: exactly one advance.

Source files
------------

// File: rtl/output_unit_pkg.sv
// Shared types for the serial bit presenter: the FSM state encoding and the
// width of the value being presented.
package output_unit_pkg;

  localparam int BITS = 8;

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

endpackage

// File: rtl/rise_detect.sv
// One-bit registered rising-edge detector with asynchronous reset.
// Because the history bit clears on reset, a level held through reset release reports one rise.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_d <= 1'b0;
    else     sig_d <= sig;
  end

  assign rise = sig & ~sig_d;

endmodule

// File: rtl/output_unit.sv
// Serial bit presenter: shows an 8-bit value one bit at a time, MSB first.
// Bits advance on a button rise or on a programmable auto-step period.
module output_unit
  import output_unit_pkg::*;
#(
  parameter int STEP_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            load,
  input  logic [BITS-1:0] load_value,
  input  logic            btn_next,
  input  logic            auto_mode,
  output logic            busy,
  output logic            bit_out,
  output logic            bit_valid,
  output logic [2:0]      bit_idx,
  output logic            done
);

  localparam logic [2:0]       LAST_CNT  = 3'd7;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

  state_t            state, state_n;
  logic [BITS-1:0]   sh, sh_n;
  logic [2:0]        cnt, cnt_n;
  logic [CNT_W-1:0]  step, step_n;
  logic              done_q, done_n;
  logic              next_rise;
  logic              tick;
  logic              adv;

  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .sig  (btn_next),
    .rise (next_rise)
  );

  // A button rise and an auto tick in the same cycle merge into one advance.
  assign tick = auto_mode && (step == STEP_LAST);
  assign adv  = next_rise | tick;

  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = cnt;
    step_n  = step;
    done_n  = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      sh_n    = '0;
      cnt_n   = '0;
      step_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          step_n = '0;
          if (load) begin
            sh_n    = load_value;
            cnt_n   = '0;
            state_n = SHOW;
          end
        end
        SHOW: begin
          if (adv) begin
            step_n = '0;
            if (cnt == LAST_CNT) begin
              done_n  = 1'b1;
              cnt_n   = '0;
              state_n = IDLE;
            end else begin
              sh_n  = {sh[BITS-2:0], 1'b0};
              cnt_n = cnt + 3'd1;
            end
          end else if (auto_mode) begin
            step_n = step + 1'b1;
          end else begin
            step_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sh     <= '0;
      cnt    <= '0;
      step   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      sh     <= sh_n;
      cnt    <= cnt_n;
      step   <= step_n;
      done_q <= done_n;
    end
  end

  // Outputs decode registered state only, so they never glitch from inputs.
  assign busy      = (state == SHOW);
  assign bit_valid = (state == SHOW);
  assign bit_out   = (state == SHOW) & sh[BITS-1];
  assign bit_idx   = (state == SHOW) ? (LAST_CNT - cnt) : 3'd0;
  assign done      = done_q;

endmodule

// File: tb/tb_output_unit.sv
// Directed self-checking bench for output_unit with a short auto-step period.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_output_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       load;
  logic [7:0] load_value;
  logic       btn_next;
  logic       auto_mode;
  logic       busy;
  logic       bit_out;
  logic       bit_valid;
  logic [2:0] bit_idx;
  logic       done;

  int checks   = 0;
  int failures = 0;

  output_unit #(.STEP_CYCLES(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .btn_next   (btn_next),
    .auto_mode  (auto_mode),
    .busy       (busy),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .bit_idx    (bit_idx),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"},  8'(busy),      8'h0);
    checkOutput({tag, "_valid"}, 8'(bit_valid), 8'h0);
    checkOutput({tag, "_bit"},   8'(bit_out),   8'h0);
    checkOutput({tag, "_idx"},   8'(bit_idx),   8'h0);
    checkOutput({tag, "_done"},  8'(done),      8'h0);
  endtask

  task automatic checkShow(input string tag, input logic exp_bit, input logic [2:0] exp_idx);
    checkOutput({tag, "_busy"}, 8'(busy),    8'h1);
    checkOutput({tag, "_bit"},  8'(bit_out), 8'(exp_bit));
    checkOutput({tag, "_idx"},  8'(bit_idx), 8'(exp_idx));
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A complete button press: one rise, held three cycles, then one low cycle.
  task automatic pressNext();
    btn_next = 1'b1;
    applyStimulus(3);
    btn_next = 1'b0;
    applyStimulus(1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] v;
    logic [2:0] exp_idx;

    rst = 1'b1; enable = 1'b0; load = 1'b0; load_value = 8'h00;
    btn_next = 1'b0; auto_mode = 1'b0;
    applyStimulus(2);
    checkIdle("reset");
    rst = 1'b0;
    enable = 1'b1;
    applyStimulus(1);

    // Manual presentation of A5
    v = 8'hA5;
    load = 1'b1; load_value = v;
    applyStimulus(1);
    load = 1'b0;
    checkShow("man_load", v[7], 3'd7);
    checkOutput("man_load_valid", 8'(bit_valid), 8'h1);
    for (int i = 0; i < 8; i++) begin
      btn_next = 1'b1;
      applyStimulus(1);
      if (i < 7) begin
        checkShow("man_step", v[6-i], 3'(6 - i));
        checkOutput("man_step_done", 8'(done), 8'h0);
      end else begin
        checkOutput("man_done", 8'(done), 8'h1);
        checkOutput("man_done_busy", 8'(busy), 8'h0);
        checkOutput("man_done_valid", 8'(bit_valid), 8'h0);
      end
      applyStimulus(1);
      checkOutput("man_hold_done", 8'(done), 8'h0);
      applyStimulus(1);
      btn_next = 1'b0;
      applyStimulus(1);
    end
    checkIdle("man_after");

    // Held button: one advance only
    v = 8'hC3;
    load = 1'b1; load_value = v;
    applyStimulus(1);
    load = 1'b0;
    checkShow("held_load", 1'b1, 3'd7);
    btn_next = 1'b1;
    applyStimulus(1);
    checkShow("held_first", 1'b1, 3'd6);
    applyStimulus(19);
    checkShow("held_end", 1'b1, 3'd6);
    btn_next = 1'b0;
    applyStimulus(1);

    // Abort with enable low at bit 3
    pressNext(); pressNext(); pressNext();
    checkShow("abort_pre", v[3], 3'd3);
    enable = 1'b0;
    applyStimulus(1);
    checkIdle("abort_en");
    applyStimulus(1);
    checkIdle("abort_en_nodone");
    enable = 1'b1;

    // Reload 3C after the abort
    v = 8'h3C;
    load = 1'b1; load_value = v;
    applyStimulus(1);
    load = 1'b0;
    checkShow("reload", 1'b0, 3'd7);
    pressNext();
    checkShow("reload_b6", 1'b0, 3'd6);
    pressNext();
    checkShow("reload_b5", 1'b1, 3'd5);

    // Load while busy is ignored
    load = 1'b1; load_value = 8'h0F;
    applyStimulus(1);
    load = 1'b0;
    checkShow("busy_load", 1'b1, 3'd5);
    pressNext();
    checkShow("busy_load_b4", 1'b1, 3'd4);

    // Asynchronous reset at bit 4
    rst = 1'b1;
    #1;
    checkIdle("async_rst");
    applyStimulus(1);
    rst = 1'b0;
    applyStimulus(1);
    checkIdle("after_rst");
    v = 8'h3C;
    load = 1'b1; load_value = v;
    applyStimulus(1);
    load = 1'b0;
    checkShow("rst_reload", 1'b0, 3'd7);
    enable = 1'b0;
    applyStimulus(1);
    enable = 1'b1;

    // Auto mode, period 4, value 81; reload in the done cycle
    auto_mode = 1'b1;
    v = 8'h81;
    load = 1'b1; load_value = v;
    applyStimulus(1);
    load = 1'b0;
    checkShow("auto_k0", v[7], 3'd7);
    for (int k = 1; k <= 32; k++) begin
      applyStimulus(1);
      if (k < 32) begin
        exp_idx = 3'(7 - k / 4);
        checkShow("auto", v[exp_idx], exp_idx);
        checkOutput("auto_nodone", 8'(done), 8'h0);
      end else begin
        checkOutput("auto_done", 8'(done), 8'h1);
        checkOutput("auto_done_busy", 8'(busy), 8'h0);
        load = 1'b1; load_value = 8'h5A;
      end
    end
    applyStimulus(1);
    load = 1'b0;
    checkShow("done_cycle_load", 1'b0, 3'd7);

    // Button rise coincident with the auto tick
    applyStimulus(3);
    btn_next = 1'b1;
    applyStimulus(1);
    checkShow("simul", 1'b1, 3'd6);
    applyStimulus(3);
    checkShow("simul_restart", 1'b1, 3'd6);
    applyStimulus(1);
    checkShow("simul_next", 1'b0, 3'd5);
    btn_next = 1'b0;
    auto_mode = 1'b0;
    enable = 1'b0;
    applyStimulus(1);
    checkIdle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
